lcd_bus_decoder: RTL and testbench



---
 rtl/lcd_bus_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: receive-side decoder and pixel mirror for an 8080-style LCD write bus
module lcd_bus_decoder #(
    parameter int LCD_W = 320,
    parameter int LCD_H = 240
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  lcd_db,
    input  logic        lcd_wr,
    input  logic        lcd_d_c,
    input  logic        lcd_rd,
    input  logic        lcd_reset,
    output logic        pxl_valid,
    output logic [10:0] pxl_x,
    output logic [10:0] pxl_y,
    output logic [11:0] pxl_rgb,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        frame_done,
    output logic        protocol_err
);
    typedef enum logic [3:0] {
        IDLE, CASET0, CASET1, CASET2, CASET3,
        PASET0, PASET1, PASET2, PASET3, RAM_HI, RAM_LO
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  s1_q, s1_d, s2_q, s2_d;
    logic        s3_q, s3_d;
    logic        prst1_q, prst1_d, prst2_q, prst2_d;
    logic        ev_q, ev_d, evdc_q, evdc_d;
    logic [7:0]  evdb_q, evdb_d;
    logic [23:0] par_q, par_d;
    logic [8:0]  sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  hi_q, hi_d;
    logic        pxl_valid_q, pxl_valid_d, frame_done_q, frame_done_d;
    logic [8:0]  pxl_x_q, pxl_x_d, pxl_y_q, pxl_y_d;
    logic [11:0] pxl_rgb_q, pxl_rgb_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        err_q, err_d;
    logic [15:0] s16, e16;
    logic        x_wrap, col_ok, row_ok;
    logic        unused_rd;

    assign unused_rd    = lcd_rd;
    assign s16          = par_q[23:8];
    assign e16          = {par_q[7:0], evdb_q};
    assign col_ok       = s16 <= e16 && e16 < 16'(LCD_W);
    assign row_ok       = s16 <= e16 && e16 < 16'(LCD_H);
    assign x_wrap       = !(x_q < ec_q);
    assign pxl_valid    = pxl_valid_q;
    assign pxl_x        = {2'b00, pxl_x_q};
    assign pxl_y        = {2'b00, pxl_y_q};
    assign pxl_rgb      = pxl_rgb_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_byte     = cmd_byte_q;
    assign frame_done   = frame_done_q;
    assign protocol_err = err_q;

    // Synchronizer, byte-event detection and command/parameter/pixel decoding
    always_comb begin
        s1_d         = {lcd_wr, lcd_d_c, lcd_db};
        s2_d         = s1_q;
        s3_d         = s2_q[9];
        prst1_d      = lcd_reset;
        prst2_d      = prst1_q;
        ev_d         = s2_q[9] & ~s3_q;
        evdc_d       = s2_q[8];
        evdb_d       = s2_q[7:0];
        state_d      = state_q;
        par_d        = par_q;
        sc_d         = sc_q;
        ec_d         = ec_q;
        sp_d         = sp_q;
        ep_d         = ep_q;
        x_d          = x_q;
        y_d          = y_q;
        hi_d         = hi_q;
        pxl_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        pxl_x_d      = pxl_x_q;
        pxl_y_d      = pxl_y_q;
        pxl_rgb_d    = pxl_rgb_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        err_d        = err_q;
        if (ev_q && !evdc_q) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = evdb_q;
            state_d     = evdb_q == 8'h2A ? CASET0 :
                          evdb_q == 8'h2B ? PASET0 :
                          (evdb_q == 8'h2C || evdb_q == 8'h3C) ? RAM_HI : IDLE;
            x_d         = evdb_q == 8'h2C ? sc_q : x_q;
            y_d         = evdb_q == 8'h2C ? sp_q : y_q;
        end else if (ev_q) begin
            case (state_q)
                CASET0, CASET1, CASET2, PASET0, PASET1, PASET2: begin
                    par_d   = {par_q[15:0], evdb_q};
                    state_d = state_q == CASET0 ? CASET1 :
                              state_q == CASET1 ? CASET2 :
                              state_q == CASET2 ? CASET3 :
                              state_q == PASET0 ? PASET1 :
                              state_q == PASET1 ? PASET2 : PASET3;
                end
                CASET3: begin
                    sc_d    = col_ok ? s16[8:0] : sc_q;
                    ec_d    = col_ok ? e16[8:0] : ec_q;
                    err_d   = err_q | !col_ok;
                    state_d = IDLE;
                end
                PASET3: begin
                    sp_d    = row_ok ? s16[8:0] : sp_q;
                    ep_d    = row_ok ? e16[8:0] : ep_q;
                    err_d   = err_q | !row_ok;
                    state_d = IDLE;
                end
                RAM_HI: begin
                    hi_d    = evdb_q;
                    state_d = RAM_LO;
                end
                RAM_LO: begin
                    pxl_valid_d  = 1'b1;
                    pxl_x_d      = x_q;
                    pxl_y_d      = y_q;
                    pxl_rgb_d    = {hi_q[7:4], hi_q[2:0], evdb_q[7], evdb_q[4:1]};
                    x_d          = x_wrap ? sc_q : x_q + 9'd1;
                    y_d          = !x_wrap ? y_q : y_q == ep_q ? sp_q : y_q + 9'd1;
                    frame_done_d = x_wrap && y_q == ep_q;
                    state_d      = RAM_HI;
                end
                default: ;
            endcase
        end
    end

    // Decoder state; a synchronized panel reset clears it just like resetN
    always_ff @(posedge clk) begin
        if (!resetN || !prst2_q) begin
            state_q      <= IDLE;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= 1'b0;
            ev_q         <= 1'b0;
            evdc_q       <= 1'b0;
            evdb_q       <= '0;
            par_q        <= '0;
            sc_q         <= '0;
            ec_q         <= 9'(LCD_W - 1);
            sp_q         <= '0;
            ep_q         <= 9'(LCD_H - 1);
            x_q          <= '0;
            y_q          <= '0;
            hi_q         <= '0;
            pxl_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pxl_x_q      <= '0;
            pxl_y_q      <= '0;
            pxl_rgb_q    <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            ev_q         <= ev_d;
            evdc_q       <= evdc_d;
            evdb_q       <= evdb_d;
            par_q        <= par_d;
            sc_q         <= sc_d;
            ec_q         <= ec_d;
            sp_q         <= sp_d;
            ep_q         <= ep_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hi_q         <= hi_d;
            pxl_valid_q  <= pxl_valid_d;
            frame_done_q <= frame_done_d;
            pxl_x_q      <= pxl_x_d;
            pxl_y_q      <= pxl_y_d;
            pxl_rgb_q    <= pxl_rgb_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
        end
    end

    // Panel-reset synchronizer and sticky error, both immune to the panel reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            prst1_q <= 1'b1;
            prst2_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            prst1_q <= prst1_d;
            prst2_q <= prst2_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: randomized bus traffic checked against a behavioural LCD model
module tb_lcd_bus_decoder;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  lcd_db = '0;
    logic        lcd_wr = 1'b0;
    logic        lcd_d_c = 1'b0;
    logic        lcd_rd = 1'b0;
    logic        lcd_reset = 1'b1;
    logic        pxl_valid, cmd_valid, frame_done, protocol_err;
    logic [10:0] pxl_x, pxl_y;
    logic [11:0] pxl_rgb;
    logic [7:0]  cmd_byte;

    lcd_bus_decoder dut (
        .clk(clk), .resetN(resetN), .lcd_db(lcd_db), .lcd_wr(lcd_wr),
        .lcd_d_c(lcd_d_c), .lcd_rd(lcd_rd), .lcd_reset(lcd_reset),
        .pxl_valid(pxl_valid), .pxl_x(pxl_x), .pxl_y(pxl_y), .pxl_rgb(pxl_rgb),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .frame_done(frame_done),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int rgb; bit fd;} pix_t;

    int   n_vec = 0, n_err = 0, cyc = 0, last_rise = 0;
    pix_t exp_pix[$];
    int   exp_cmd[$];
    pix_t p;
    int   m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_mode, m_hi;
    bit   m_err, m_have_hi;
    int   m_par[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset(input bit keep_err);
        m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239; m_x = 0; m_y = 0;
        m_mode = 0; m_have_hi = 0; m_par.delete();
        if (!keep_err) m_err = 0;
    endtask

    task automatic model_byte(input bit dc, input int b);
        int s, e, lim, rgb;
        bit fd;
        if (!dc) begin
            exp_cmd.push_back(b);
            m_par.delete();
            m_have_hi = 0;
            m_mode = b == 'h2A ? 1 : b == 'h2B ? 2 : (b == 'h2C || b == 'h3C) ? 3 : 0;
            if (b == 'h2C) begin m_x = m_sc; m_y = m_sp; end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_par.push_back(b);
            if (m_par.size() == 4) begin
                s = m_par[0] * 256 + m_par[1];
                e = m_par[2] * 256 + m_par[3];
                lim = m_mode == 1 ? 320 : 240;
                if (s <= e && e < lim) begin
                    if (m_mode == 1) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end else m_err = 1;
                m_mode = 0;
                m_par.delete();
            end
        end else if (m_mode == 3) begin
            if (!m_have_hi) begin
                m_hi = b; m_have_hi = 1;
            end else begin
                rgb = ((m_hi >> 4) << 8) | ((((m_hi & 7) << 1) | (b >> 7)) << 4) | ((b >> 1) & 15);
                fd = 0;
                exp_pix.push_back('{m_x, m_y, rgb, 1'b0});
                if (m_x < m_ec) m_x = m_x + 1;
                else begin
                    m_x = m_sc;
                    if (m_y == m_ep) begin m_y = m_sp; fd = 1; end
                    else m_y = (m_y + 1) % 512;
                end
                exp_pix[exp_pix.size() - 1].fd = fd;
                m_have_hi = 0;
            end
        end
    endtask

    task automatic send(input bit dc, input int b);
        model_byte(dc, b);
        lcd_d_c = dc; lcd_db = 8'(b); lcd_rd = 1'($urandom);
        repeat (2) @(negedge clk);
        lcd_wr = 1'b1; last_rise = cyc + 1; lcd_rd = 1'($urandom);
        repeat (3) @(negedge clk);
        lcd_wr = 1'b0; lcd_rd = 1'($urandom);
        repeat (2) @(negedge clk);
        check("protocol_err", protocol_err, m_err);
    endtask

    task automatic pix(input int c);
        send(1, c >> 8);
        send(1, c & 255);
    endtask

    task automatic window(input int cmd, input int s, input int e);
        send(0, cmd);
        send(1, (s >> 8) & 255); send(1, s & 255);
        send(1, (e >> 8) & 255); send(1, e & 255);
    endtask

    task automatic panel_reset();
        lcd_reset = 1'b0;
        repeat (3) @(negedge clk);
        lcd_reset = 1'b1;
        repeat (3) @(negedge clk);
        model_reset(1);
        check("panel_rst_cmd", cmd_byte, 0);
    endtask

    task automatic drain(input string tag);
        check({tag, "_pix_left"}, exp_pix.size(), 0);
        check({tag, "_cmd_left"}, exp_cmd.size(), 0);
        exp_pix.delete(); exp_cmd.delete();
    endtask

    // Compare every output pulse against the model's expectation queues
    always @(negedge clk) if (resetN) begin
        if (pxl_valid || frame_done) begin
            if (exp_pix.size() == 0) check("pxl_extra", {pxl_valid, frame_done}, 0);
            else begin
                p = exp_pix.pop_front();
                check("pxl_valid", pxl_valid, 1);
                check("pxl_x", pxl_x, p.x);
                check("pxl_y", pxl_y, p.y);
                check("pxl_rgb", pxl_rgb, p.rgb);
                check("frame_done", frame_done, p.fd);
                check("pxl_lat", cyc - last_rise, 3);
            end
        end
        if (cmd_valid) begin
            if (exp_cmd.size() == 0) check("cmd_extra", cmd_valid, 0);
            else begin
                check("cmd_byte", cmd_byte, exp_cmd.pop_front());
                check("cmd_lat", cyc - last_rise, 3);
            end
        end
    end

    initial begin
        int s, e, lim, op;
        model_reset(0);
        repeat (3) @(negedge clk);
        check("rst_outs", {pxl_valid, pxl_x, pxl_y, pxl_rgb, cmd_valid, cmd_byte, frame_done, protocol_err}, 0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        send(0, 'h2C); pix('hF800); pix('h07E0);
        drain("basic");

        window('h2A, 10, 12); window('h2B, 5, 6); send(0, 'h2C);
        repeat (7) pix(int'($urandom_range(65535)));
        drain("wrap");

        repeat (3) pix(int'($urandom_range(65535)));
        send(1, 'h1F); send(0, 'h2C); send(1, 'h00); send(1, 'h1F);
        drain("abort");

        window('h2A, 0, 319); window('h2B, 0, 239); send(0, 'h2C);
        repeat (3) pix(int'($urandom_range(65535)));
        send(0, 'h3C); pix('h1234);
        send(0, 'h2C); pix('h4321);
        drain("continue");

        panel_reset();
        window('h2A, 0, 320); send(0, 'h2C);
        repeat (330) pix(int'($urandom_range(65535)));
        panel_reset();
        send(0, 'h2C); pix('hFFFF);
        drain("error");

        send(0, 'h2C); send(1, 'hAB);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        check("midrst_outs", {pxl_valid, pxl_x, pxl_y, pxl_rgb, cmd_valid, cmd_byte, frame_done, protocol_err}, 0);
        model_reset(0);
        exp_pix.delete(); exp_cmd.delete();
        repeat (2) @(negedge clk);
        send(1, 'h55); send(0, 'h2C); pix('hF81F);
        drain("midrst");

        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(9));
            if (op <= 1) begin
                lim = op == 0 ? 320 : 240;
                s = int'($urandom_range(lim - 1));
                e = s + int'($urandom_range(3));
                if ($urandom_range(9) == 0) e = lim + int'($urandom_range(400));
                else if ($urandom_range(9) == 0 && s > 0) e = s - 1;
                else if (e >= lim) e = lim - 1;
                window(op == 0 ? 'h2A : 'h2B, s, e);
            end else if (op <= 5) begin
                send(0, op <= 3 ? 'h2C : 'h3C);
                repeat ($urandom_range(1, 8)) pix(int'($urandom_range(65535)));
            end else if (op == 6) send(1, int'($urandom_range(255)));
            else if (op == 7) send(0, int'($urandom_range(255)));
            else if (op == 8) panel_reset();
            else pix(int'($urandom_range(65535)));
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
